// File: rtl/stack_seq_pkg.sv
// Shared opcodes, error codes, FSM encoding and depth limit for the stack command sequencer.
package stack_seq_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  // The stack pointer is 5 bits, so 31 entries is the most it can hold without wrapping.
  localparam int DEPTH_MAX_DEFAULT = 31;

  typedef enum logic [2:0] {
    IDLE,
    POP_A,
    POP_B,
    PUSH_R,
    PUSH_2,
    DONE,
    ERR
  } state_t;

  // Number of entries an opcode consumes before it can push anything back.
  function automatic logic [5:0] need_of(input logic [2:0] op);
    logic [5:0] n;
    case (op)
      OP_PUSH:                n = 6'd0;
      OP_POP, OP_NOT, OP_DUP: n = 6'd1;
      default:                n = 6'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational ALU step: a is the old top of stack, b the entry beneath it.
module stack_seq_alu
  import stack_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  always_comb begin
    result = 8'h00;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_NOT:  result = ~a;
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/stack_seq_ctrl.sv
// Stack command sequencer: turns one accepted command into Push/Pop strobes,
// runs the ALU step and guards the depth against underflow and overflow.
module stack_seq_ctrl
  import stack_seq_pkg::*;
#(
  parameter int DEPTH_MAX = DEPTH_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [7:0] stk_din,
  input  logic [7:0] stk_top,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic [5:0] depth,
  output logic       busy
);

  localparam logic [5:0] DEPTH_LIMIT = 6'(DEPTH_MAX);

  state_t     state;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] alu_a;
  logic [7:0] alu_y;
  logic       accept;
  logic       under;
  logic       over;

  assign accept = cmd_valid && cmd_ready;
  assign under  = depth < need_of(cmd_op);
  assign over   = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) && (depth >= DEPTH_LIMIT);

  // NOT pushes straight out of POP_A, before a_q has captured the popped value.
  assign alu_a = (state == POP_A) ? stk_top : a_q;

  stack_seq_alu u_alu (
    .op     (op_q),
    .a      (alu_a),
    .b      (stk_top),
    .result (alu_y)
  );

  // Outputs are registered for the state being entered, so they always match the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_PUSH;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      depth     <= 6'd0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;

      if (stk_pop)
        depth <= depth - 6'd1;
      else if (stk_push)
        depth <= depth + 6'd1;

      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            a_q       <= stk_top;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (under) begin
              state     <= ERR;
              err_valid <= 1'b1;
              err_code  <= ERR_UNDER;
            end else if (over) begin
              state     <= ERR;
              err_valid <= 1'b1;
              err_code  <= ERR_OVER;
            end else if (cmd_op == OP_PUSH) begin
              state    <= PUSH_R;
              stk_push <= 1'b1;
              stk_din  <= cmd_data;
            end else if (cmd_op == OP_DUP) begin
              state    <= PUSH_R;
              stk_push <= 1'b1;
              stk_din  <= stk_top;
            end else begin
              state   <= POP_A;
              stk_pop <= 1'b1;
            end
          end
        end
        POP_A: begin
          a_q <= stk_top;
          if (op_q == OP_POP) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= stk_top;
          end else if (op_q == OP_NOT) begin
            state    <= PUSH_R;
            stk_push <= 1'b1;
            stk_din  <= alu_y;
          end else begin
            state   <= POP_B;
            stk_pop <= 1'b1;
          end
        end
        POP_B: begin
          b_q      <= stk_top;
          state    <= PUSH_R;
          stk_push <= 1'b1;
          stk_din  <= (op_q == OP_SWAP) ? a_q : alu_y;
        end
        PUSH_R: begin
          if (op_q == OP_SWAP) begin
            state    <= PUSH_2;
            stk_push <= 1'b1;
            stk_din  <= b_q;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= stk_din;
          end
        end
        PUSH_2: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_data  <= stk_din;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: a queue-based stack feeds stk_top, and a transaction-level
// model predicts every output cycle by cycle from the command semantics.
module tb_stack_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_top;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err_valid;
  logic [1:0] err_code;
  logic [5:0] depth;
  logic       busy;

  stack_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_top   (stk_top),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err_valid (err_valid),
    .err_code  (err_code),
    .depth     (depth),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ready;
    bit       busy;
    bit       push;
    bit       pop;
    bit [7:0] din;
    bit       rv;
    bit [7:0] rd;
    bit       ev;
    bit [1:0] ec;
    int       dep;
  } rec_t;

  rec_t       exp_q[$];
  bit   [7:0] mstk[$];
  bit   [7:0] tstk[$];
  logic [7:0] dut_rsp[$];
  logic [1:0] dut_err[$];
  int         dut_lat[$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, pop_cnt = 0, push_cnt = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%02h expected=0x%02h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=ready cycle=%0d", name, cyc);
  endtask

  function automatic rec_t mk(bit push, bit pop, bit [7:0] din, bit rv, bit [7:0] rd,
                              bit ev, bit [1:0] ec, int dep);
    rec_t r;
    r.ready = 1'b0; r.busy = 1'b1; r.push = push; r.pop = pop; r.din = din;
    r.rv = rv; r.rd = rd; r.ev = ev; r.ec = ec; r.dep = dep;
    return r;
  endfunction

  // Expected per-cycle outputs for one accepted command, straight from the command semantics.
  task automatic buildSequence(input logic [2:0] op, input logic [7:0] d);
    int dd, need;
    bit [7:0] a, b, r;
    dd = mstk.size();
    need = (op == 3'd0) ? 0 : ((op == 3'd1 || op == 3'd5 || op == 3'd6) ? 1 : 2);
    if (dd < need) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b01, dd));
    end else if ((op == 3'd0 || op == 3'd6) && dd >= 31) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b10, dd));
    end else begin
      case (op)
        3'd0: begin
          exp_q.push_back(mk(1, 0, d, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(0, 0, 0, 1, d, 0, 0, dd + 1));
          mstk.push_back(d);
        end
        3'd1: begin
          a = mstk.pop_back();
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(0, 0, 0, 1, a, 0, 0, dd - 1));
        end
        3'd2, 3'd3, 3'd4: begin
          a = mstk.pop_back();
          b = mstk.pop_back();
          r = (op == 3'd2) ? b + a : ((op == 3'd3) ? b - a : b & a);
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd - 1));
          exp_q.push_back(mk(1, 0, r, 0, 0, 0, 0, dd - 2));
          exp_q.push_back(mk(0, 0, 0, 1, r, 0, 0, dd - 1));
          mstk.push_back(r);
        end
        3'd5: begin
          a = mstk.pop_back();
          r = ~a;
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(1, 0, r, 0, 0, 0, 0, dd - 1));
          exp_q.push_back(mk(0, 0, 0, 1, r, 0, 0, dd));
          mstk.push_back(r);
        end
        3'd6: begin
          a = mstk[$];
          exp_q.push_back(mk(1, 0, a, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(0, 0, 0, 1, a, 0, 0, dd + 1));
          mstk.push_back(a);
        end
        default: begin
          a = mstk.pop_back();
          b = mstk.pop_back();
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd));
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, dd - 1));
          exp_q.push_back(mk(1, 0, a, 0, 0, 0, 0, dd - 2));
          exp_q.push_back(mk(1, 0, b, 0, 0, 0, 0, dd - 1));
          exp_q.push_back(mk(0, 0, 0, 1, b, 0, 0, dd));
          mstk.push_back(a);
          mstk.push_back(b);
        end
      endcase
    end
  endtask

  // Behavioural 32-entry stack driven by the DUT strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tstk.delete();
      stk_top <= 8'h00;
    end else begin
      if (stk_push)
        tstk.push_back(stk_din);
      else if (stk_pop && tstk.size() > 0)
        void'(tstk.pop_back());
      stk_top <= (tstk.size() > 0) ? tstk[$] : 8'h00;
    end
  end

  // Compare every cycle on the falling edge, then predict the next command if one is being accepted.
  always @(negedge clk) begin : cmp
    rec_t e;
    bit   idle;
    cyc++;
    if (rst) begin
      exp_q.delete();
      mstk.delete();
    end
    idle = (exp_q.size() == 0);
    if (idle) begin
      e = mk(0, 0, 0, 0, 0, 0, 0, mstk.size());
      e.ready = 1'b1;
      e.busy  = 1'b0;
    end else begin
      e = exp_q.pop_front();
    end
    checkOutput("cmd_ready", 8'(cmd_ready), 8'(e.ready));
    checkOutput("busy",      8'(busy),      8'(e.busy));
    checkOutput("stk_push",  8'(stk_push),  8'(e.push));
    checkOutput("stk_pop",   8'(stk_pop),   8'(e.pop));
    checkOutput("stk_din",   stk_din,       e.din);
    checkOutput("rsp_valid", 8'(rsp_valid), 8'(e.rv));
    checkOutput("rsp_data",  rsp_data,      e.rd);
    checkOutput("err_valid", 8'(err_valid), 8'(e.ev));
    checkOutput("err_code",  8'(err_code),  8'(e.ec));
    checkOutput("depth",     8'(depth),     8'(e.dep));
    if (stk_push) push_cnt++;
    if (stk_pop)  pop_cnt++;
    if (rsp_valid) begin
      dut_rsp.push_back(rsp_data);
      dut_lat.push_back(cyc - acc_cyc);
    end
    if (err_valid) begin
      dut_err.push_back(err_code);
      dut_lat.push_back(cyc - acc_cyc);
    end
    if (!rst && idle && cmd_valid) begin
      buildSequence(cmd_op, cmd_data);
      acc_cyc = cyc;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      if (!cmd_ready) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = 8'($urandom);
        guard++;
      end
    end while (!cmd_ready && guard < 100);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      failTimeout("accept_wait");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_data  = 8'($urandom);
  endtask

  task automatic waitIdle();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      guard++;
    end while (!cmd_ready && guard < 100);
    if (!cmd_ready) failTimeout("idle_wait");
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic checkRsp(input string name, input int back, input logic [7:0] exp);
    if (dut_rsp.size() <= back) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=missing expected=0x%02h", name, exp);
    end else begin
      checkOutput(name, dut_rsp[dut_rsp.size() - 1 - back], exp);
    end
  endtask

  task automatic checkErr(input string name, input logic [1:0] exp);
    if (dut_err.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=missing expected=%0d", name, exp);
    end else begin
      checkOutput(name, 8'(dut_err[$]), 8'(exp));
    end
  endtask

  task automatic checkLat(input string name, input int exp);
    if (dut_lat.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=missing expected=%0d", name, exp);
    end else begin
      checkOutput(name, 8'(dut_lat[$]), 8'(exp));
    end
  endtask

  initial begin
    int p0, q0, n0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_ready", 8'(cmd_ready), 8'h01);
    checkOutput("reset_depth", 8'(depth), 8'h00);
    checkOutput("reset_busy", 8'(busy), 8'h00);

    // PUSH 5, PUSH 3, ADD
    applyStimulus(3'd0, 8'h05);
    applyStimulus(3'd0, 8'h03);
    waitIdle();
    checkOutput("add_pre_depth", 8'(depth), 8'h02);
    p0 = pop_cnt; q0 = push_cnt;
    applyStimulus(3'd2, 8'h00);
    waitIdle();
    checkRsp("push05_rsp", 2, 8'h05);
    checkRsp("push03_rsp", 1, 8'h03);
    checkRsp("add_rsp", 0, 8'h08);
    checkOutput("add_depth", 8'(depth), 8'h01);
    checkOutput("add_pops", 8'(pop_cnt - p0), 8'h02);
    checkOutput("add_pushes", 8'(push_cnt - q0), 8'h01);
    checkLat("add_latency", 4);
    checkOutput("model_depth", 8'(mstk.size()), 8'h01);

    // SUB wraps
    resetDut();
    applyStimulus(3'd0, 8'h02);
    applyStimulus(3'd0, 8'h05);
    applyStimulus(3'd3, 8'h00);
    waitIdle();
    checkRsp("sub_rsp", 0, 8'hFD);
    checkOutput("sub_depth", 8'(depth), 8'h01);

    // SWAP then two POPs
    resetDut();
    applyStimulus(3'd0, 8'hA1);
    applyStimulus(3'd0, 8'h3C);
    applyStimulus(3'd7, 8'h00);
    waitIdle();
    checkRsp("swap_rsp", 0, 8'hA1);
    checkLat("swap_latency", 5);
    applyStimulus(3'd1, 8'h00);
    applyStimulus(3'd1, 8'h00);
    waitIdle();
    checkRsp("pop1_rsp", 1, 8'hA1);
    checkRsp("pop2_rsp", 0, 8'h3C);
    checkLat("pop_latency", 2);

    // underflow on empty stack
    resetDut();
    p0 = pop_cnt; q0 = push_cnt; n0 = dut_rsp.size();
    applyStimulus(3'd1, 8'h00);
    waitIdle();
    checkErr("under_code", 2'b01);
    checkLat("under_latency", 1);
    checkOutput("under_depth", 8'(depth), 8'h00);
    checkOutput("under_strobes", 8'((pop_cnt - p0) + (push_cnt - q0)), 8'h00);
    checkOutput("under_no_rsp", 8'(dut_rsp.size() - n0), 8'h00);

    // fill to the limit
    resetDut();
    for (int i = 0; i < 31; i++) applyStimulus(3'd0, 8'(i));
    waitIdle();
    checkOutput("full_depth", 8'(depth), 8'd31);
    applyStimulus(3'd6, 8'h00);
    waitIdle();
    checkErr("over_code", 2'b10);
    checkOutput("over_depth", 8'(depth), 8'd31);
    applyStimulus(3'd1, 8'h00);
    waitIdle();
    checkRsp("full_pop_rsp", 0, 8'h1E);
    checkOutput("full_pop_depth", 8'(depth), 8'd30);
    applyStimulus(3'd6, 8'h00);
    waitIdle();
    checkRsp("dup_rsp", 0, 8'h1D);
    checkOutput("dup_depth", 8'(depth), 8'd31);
    checkLat("dup_latency", 2);

    // reset during POP_B of an ADD
    resetDut();
    applyStimulus(3'd0, 8'h11);
    applyStimulus(3'd0, 8'h22);
    waitIdle();
    n0 = dut_rsp.size();
    applyStimulus(3'd2, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_no_rsp", 8'(dut_rsp.size() - n0), 8'h00);
    checkOutput("abort_depth", 8'(depth), 8'h00);
    checkOutput("abort_ready", 8'(cmd_ready), 8'h01);
    applyStimulus(3'd0, 8'h7F);
    waitIdle();
    checkRsp("after_abort_rsp", 0, 8'h7F);

    // randomized traffic against the model
    resetDut();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      applyStimulus(op, 8'($urandom));
    end
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_seq_ctrl.md
# stack_seq_ctrl

Command sequencer for the 32-entry, 8-bit stack. It accepts one stack-machine command at a time over a valid/ready handshake and issues the cycle-by-cycle Push/Pop strobes and data to the stack. It performs the 8-bit ALU step between pops and pushes, and tracks depth so the stack's 5-bit pointer never wraps or underflows. It sits between the instruction-decode path and the stack datapath. Each command ends in exactly one response pulse or one error pulse.

## Interface
- DEPTH_MAX, 31: highest legal depth. Must be ≤ 31 so the stack's 5-bit pointer never wraps to 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; must drive the stack's rst too.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high iff state == IDLE.
- cmd_op  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 NOT, 6 DUP, 7 SWAP.
- cmd_data  in  8  immediate for PUSH; ignored otherwise.
- stk_push  out  1  to stack Push.
- stk_pop  out  1  to stack Pop; never high together with stk_push.
- stk_din  out  8  to stack d_in; 0 when stk_push is low.
- stk_top  in  8  stack out (combinational top of stack).
- rsp_valid  out  1  one-cycle pulse: command completed.
- rsp_data  out  8  result; valid with rsp_valid, 0 otherwise.
- err_valid  out  1  one-cycle pulse: command rejected, stack untouched.
- err_code  out  2  01 underflow, 10 overflow; 00 when err_valid is low.
- depth  out  6  current entry count, 0..DEPTH_MAX.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, POP_A, POP_B, PUSH_R, PUSH_2, DONE, ERR.
- Accept on cmd_valid && cmd_ready. On accept, latch op and data, and capture a = stk_top (used by DUP).
- Check order at accept: underflow first, then overflow. Failure -> ERR (err_valid = 1) -> IDLE.
  - Underflow: depth < need. Need is 1 for POP/NOT/DUP, 2 for ADD/SUB/AND/SWAP, 0 for PUSH.
  - Overflow: PUSH/DUP with depth == DEPTH_MAX. All other ops have net depth change ≤ 0 and cannot overflow.
- Sequences from IDLE:
  - PUSH: PUSH_R(imm) -> DONE.
  - POP: POP_A -> DONE.
  - ADD/SUB/AND: POP_A -> POP_B -> PUSH_R(f(a,b)) -> DONE.
  - NOT: POP_A -> PUSH_R(~a) -> DONE.
  - DUP: PUSH_R(a) -> DONE.
  - SWAP: POP_A -> POP_B -> PUSH_R(a) -> PUSH_2(b) -> DONE.
- State actions:
  - POP_A: register a = stk_top and assert stk_pop.
  - POP_B: register b = stk_top and assert stk_pop.
  - PUSH_R / PUSH_2: assert stk_push with stk_din = value.
- Arithmetic: a = old top, b = entry below it. ADD = b+a mod 256, SUB = b−a mod 256 (two's complement wrap), AND = b&a. No flags.
- rsp_data: pushed value for PUSH/ADD/SUB/AND/NOT/DUP; popped a for POP; b (new top) for SWAP.
- depth: −1 on every stk_pop cycle, +1 on every stk_push cycle, updated at the same edge as the stack pointer.
- cmd_valid is ignored while busy. Unaccepted commands need not be held stable.

## Timing
- Reset: state IDLE, depth 0, a = b = 0. All outputs 0 except cmd_ready = 1.
- Reset mid-sequence aborts the command: no rsp/err pulse, depth 0. The stack resets together with the controller.
- Latency (accept edge -> rsp_valid high):
  - 2 cycles: PUSH, POP, DUP.
  - 3 cycles: NOT.
  - 4 cycles: ADD, SUB, AND.
  - 5 cycles: SWAP.
  - Errors: err_valid high in the cycle after accept.
- cmd_ready is low from accept until the cycle after DONE/ERR. Back-to-back PUSHes therefore run at 3 cycles each.
- Stack outputs are decoded from state (Moore). stk_top is sampled in the cycle the pop strobe is high, before the edge that moves the pointer.

## Structure
- Shared package stack_seq_pkg holds:
  - opcode constants OP_PUSH..OP_SWAP;
  - ERR_NONE / ERR_UNDER / ERR_OVER;
  - the state encoding;
  - DEPTH_MAX default.
- One sub-module, stack_seq_alu: combinational (op, a, b) -> result for ADD/SUB/AND/NOT. The FSM, depth counter and operand registers stay in the top.

## Test plan
- Reset, then PUSH 0x05, PUSH 0x03, ADD:
  - responses 0x05, 0x03, 0x08; depth 2 -> 1;
  - ADD shows exactly 2 stk_pop cycles, then 1 stk_push with stk_din 0x08.
- PUSH 0x02, PUSH 0x05, SUB -> rsp 0xFD (2−5 wraps); depth 1.
- PUSH 0xA1, PUSH 0x3C, SWAP, then POP, POP:
  - SWAP rsp 0xA1;
  - POPs return 0xA1 then 0x3C;
  - SWAP latency 5 cycles.
- Empty stack, POP -> err_valid with err_code 01 one cycle after accept; no stack strobes; depth stays 0.
- 31 PUSHes of 0x00..0x1E:
  - then DUP -> err 10, depth stays 31;
  - then POP -> rsp 0x1E, depth 30;
  - then DUP -> rsp 0x1D, depth 31.
- Reset asserted during POP_B of an ADD -> no response pulse, depth 0, cmd_ready 1. A following PUSH 0x7F -> rsp 0x7F.
